// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: sweeps a 3-input combinational function through all eight
// input combinations, waits a programmable settle time on each one, samples
// the function output and compares it to a golden truth table latched at start.
module tt_sweep_ctrl #(
  // Cycles each input combination is held before sampling (1..15).
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  input  logic       f_in,
  output logic [2:0] abc,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [3:0] err_count,
  output logic       match
);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

  localparam logic [3:0] SettleLoad = 4'(SETTLE);
  localparam logic [3:0] ErrMax     = 4'd8;

  state_e     state_q;
  logic [2:0] abc_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] result_q;
  logic [7:0] exp_q;
  logic [3:0] err_q;
  logic [3:0] cnt_q;
  logic       match_q;

  // Sampled value disagrees with the latched golden bit for the current minterm.
  logic       miss;
  // Error count after the current SAMPLE cycle; capped so it can never wrap.
  logic [3:0] err_next;

  // Mismatch detection and saturating error increment for the SAMPLE cycle.
  always_comb begin
    miss     = f_in ^ exp_q[abc_q];
    err_next = err_q;
    if (miss && (err_q < ErrMax)) begin
      err_next = err_q + 4'd1;
    end
  end

  // Sweep sequencer: all state and outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      abc_q    <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 8'h00;
      exp_q    <= 8'h00;
      err_q    <= 4'd0;
      cnt_q    <= 4'd0;
      match_q  <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only the SAMPLE->DONE step raises it.
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // abort is deliberately not looked at here: start always wins in IDLE.
          if (start) begin
            state_q  <= StSettle;
            abc_q    <= 3'd0;
            busy_q   <= 1'b1;
            exp_q    <= expected;
            result_q <= 8'h00;
            err_q    <= 4'd0;
            match_q  <= 1'b0;
            cnt_q    <= SettleLoad;
          end
        end

        StSettle: begin
          if (abort) begin
            state_q <= StIdle;
            abc_q   <= 3'd0;
            busy_q  <= 1'b0;
            match_q <= 1'b0;
            cnt_q   <= 4'd0;
          end else if (cnt_q <= 4'd1) begin
            state_q <= StSample;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        StSample: begin
          // An aborted SAMPLE cycle leaves result/err_count with the partial sweep.
          if (abort) begin
            state_q <= StIdle;
            abc_q   <= 3'd0;
            busy_q  <= 1'b0;
            match_q <= 1'b0;
            cnt_q   <= 4'd0;
          end else begin
            result_q[abc_q] <= f_in;
            err_q           <= err_next;
            if (abc_q == 3'd7) begin
              // abc stays at 7; match uses the count including this last sample.
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              match_q <= (err_next == 4'd0);
            end else begin
              state_q <= StSettle;
              abc_q   <= abc_q + 3'd1;
              cnt_q   <= SettleLoad;
            end
          end
        end

        StDone: begin
          // start and abort are both ignored for this one cycle.
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign abc       = abc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign err_count = err_q;
  assign match     = match_q;

  // busy mirrors exactly the two working states.
  assert property (@(posedge clk) disable iff (!rst_n)
    busy_q == ((state_q == StSettle) || (state_q == StSample)));

  // The error count is bounded by the number of minterms.
  assert property (@(posedge clk) disable iff (!rst_n) err_q <= ErrMax);

  // done never lasts longer than one cycle.
  assert property (@(posedge clk) disable iff (!rst_n) done_q |=> !done_q);

  // done is only ever seen while sitting in DONE.
  assert property (@(posedge clk) disable iff (!rst_n) done_q |-> (state_q == StDone));

endmodule
